// File: rtl/aes_dr_pkg.sv
// Shared constants and types for the dual-rail (T/F) AES SubBytes datapath.
package aes_dr_pkg;

  localparam int N    = 128;
  localparam int BYTE = 8;

  // All-zero spacer that is driven on both rails while precharging.
  localparam logic [N-1:0] SPACER = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    CAPT = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [N-1:0] t;
    logic [N-1:0] f;
  } dr_word_t;

endpackage

// File: rtl/dr_valid_check.sv
// Combinational dual-rail code check: high when every (T,F) bit pair is 01 or 10.
module dr_valid_check #(
  parameter int W = 128
) (
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] f_i,
  output logic         ok_o
);

  assign ok_o = &(t_i ^ f_i);

endmodule

// File: rtl/subbytes_seq_ctrl.sv
// Precharge/evaluate sequencer for the dual-rail SubBytes array.
// Optional dual-rail code checker with sticky Fault: define DUAL_RAIL_CHECK_EN.
module subbytes_seq_ctrl
  import aes_dr_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int PRE_CYCLES = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Data_In_T,
  input  logic [N-1:0] Data_In_F,
  output logic         Busy,
  output logic         Done,
  output logic [1:0]   Multi_Cycle_State,
  output logic         Flipflop_Indicator,
  output logic [N-1:0] SubByte_In_T,
  output logic [N-1:0] SubByte_In_F,
  input  logic [N-1:0] SubByte_Out_T,
  input  logic [N-1:0] SubByte_Out_F,
  output logic [N-1:0] Data_Out_T,
  output logic [N-1:0] Data_Out_F,
  output logic         Fault
);

  ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dr_word_t    lat_q, lat_d;
  dr_word_t    sbin_q, sbin_d;
  dr_word_t    dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ff_q, ff_d;
  logic [1:0]  mcs_q, mcs_d;
  logic        start_acc;
  logic        fault_d;

  assign start_acc = (state_q == IDLE) && Start;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      sbin_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ff_q    <= 1'b0;
      mcs_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      sbin_q  <= sbin_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ff_q    <= ff_d;
      mcs_q   <= mcs_d;
    end
  end

  // cnt_q counts precharge cycles in PRE and the stage index in EVAL
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = PRE;
          cnt_d   = '0;
        end
      end
      PRE: begin
        if (cnt_q == 4'(PRE_CYCLES - 1)) begin
          state_d = EVAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EVAL: begin
        if (cnt_q == 4'(STAGES - 1)) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so that every port is a flop
  always_comb begin
    lat_d = lat_q;
    if (start_acc) begin
      lat_d.t = Data_In_T;
      lat_d.f = Data_In_F;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_q == CAPT);
    ff_d   = (state_d == EVAL) || (state_d == CAPT);

    if (state_d == EVAL)      mcs_d = cnt_d[1:0];
    else if (state_d == CAPT) mcs_d = mcs_q;
    else                      mcs_d = 2'd0;

    sbin_d.t = ff_d ? lat_q.t : SPACER;
    sbin_d.f = ff_d ? lat_q.f : SPACER;

    dout_d = dout_q;
    if (state_q == CAPT) begin
      dout_d.t = fault_d ? SPACER : SubByte_Out_T;
      dout_d.f = fault_d ? SPACER : SubByte_Out_F;
    end
  end

`ifdef DUAL_RAIL_CHECK_EN
  logic in_ok;
  logic out_ok;
  logic fault_q;

  dr_valid_check #(.W(N)) u_in_chk (
    .t_i  (Data_In_T),
    .f_i  (Data_In_F),
    .ok_o (in_ok)
  );

  dr_valid_check #(.W(N)) u_out_chk (
    .t_i  (SubByte_Out_T),
    .f_i  (SubByte_Out_F),
    .ok_o (out_ok)
  );

  assign fault_d = fault_q | (start_acc & ~in_ok) | ((state_q == CAPT) & ~out_ok);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign Fault = fault_q;
`else
  assign fault_d = 1'b0;
  assign Fault   = 1'b0;
`endif

  assign Busy               = busy_q;
  assign Done               = done_q;
  assign Multi_Cycle_State  = mcs_q;
  assign Flipflop_Indicator = ff_q;
  assign SubByte_In_T       = sbin_q.t;
  assign SubByte_In_F       = sbin_q.f;
  assign Data_Out_T         = dout_q.t;
  assign Data_Out_F         = dout_q.f;

endmodule

// File: tb/tb_subbytes_seq_ctrl.sv
// Directed + randomized bench for subbytes_seq_ctrl with an arithmetic AES S-box model.
module tb_subbytes_seq_ctrl;

  localparam int W   = 128;
  localparam int PRE = 1;
  localparam int STG = 4;
  localparam int LAT = PRE + STG + 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] Data_In_T = '0;
  logic [W-1:0] Data_In_F = '0;
  logic         Busy, Done, Flipflop_Indicator, Fault;
  logic [1:0]   Multi_Cycle_State;
  logic [W-1:0] SubByte_In_T, SubByte_In_F;
  logic [W-1:0] SubByte_Out_T, SubByte_Out_F;
  logic [W-1:0] Data_Out_T, Data_Out_F;
  logic [W-1:0] inj = '0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] cur_dout_t = '0;
  logic [W-1:0] cur_dout_f = '0;
  logic         exp_fault  = 1'b0;

  subbytes_seq_ctrl #(.STAGES(STG), .PRE_CYCLES(PRE)) dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .Start              (Start),
    .Data_In_T          (Data_In_T),
    .Data_In_F          (Data_In_F),
    .Busy               (Busy),
    .Done               (Done),
    .Multi_Cycle_State  (Multi_Cycle_State),
    .Flipflop_Indicator (Flipflop_Indicator),
    .SubByte_In_T       (SubByte_In_T),
    .SubByte_In_F       (SubByte_In_F),
    .SubByte_Out_T      (SubByte_Out_T),
    .SubByte_Out_F      (SubByte_Out_F),
    .Data_Out_T         (Data_Out_T),
    .Data_Out_F         (Data_Out_F),
    .Fault              (Fault)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box = affine(x^254) over GF(2^8)
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = v;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [W-1:0] sbox_word(input logic [W-1:0] v);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < W / 8; i++) o[i*8 +: 8] = sbox(v[i*8 +: 8]);
    return o;
  endfunction

  // Behavioural SubBytes array: spacer in, spacer out; evaluate gives S-box on T, complement on F
  always_comb begin
    SubByte_Out_T = '0;
    SubByte_Out_F = '0;
    if (Flipflop_Indicator) begin
      SubByte_Out_T = sbox_word(SubByte_In_T);
      SubByte_Out_F = ~SubByte_Out_T;
    end
    SubByte_Out_T = SubByte_Out_T | inj;
    SubByte_Out_F = SubByte_Out_F | inj;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"}, W'(Busy), '0);
    chk({tag, ".done"}, W'(Done), '0);
    chk({tag, ".mcs"},  W'(Multi_Cycle_State), '0);
    chk({tag, ".ffi"},  W'(Flipflop_Indicator), '0);
    chk({tag, ".sbt"},  SubByte_In_T, '0);
    chk({tag, ".sbf"},  SubByte_In_F, '0);
    chk({tag, ".dot"},  Data_Out_T, '0);
    chk({tag, ".dof"},  Data_Out_F, '0);
    chk({tag, ".flt"},  W'(Fault), '0);
  endtask

  // One operation: k counts edges from the Start-sampling edge (k=1) to Done (k=LAT)
  task automatic run_op(input string tag, input logic [W-1:0] t, input logic [W-1:0] f,
                        input logic [W-1:0] exp_t, input bit hold, input bit pulses, input bit do_inj);
    bit ff_exp;
    Data_In_T = t;
    Data_In_F = f;
    Start     = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT) begin
        inj = '0;
        if (do_inj) exp_fault = 1'b1;
        cur_dout_t = exp_fault ? '0 : exp_t;
        cur_dout_f = exp_fault ? '0 : ~exp_t;
      end
      ff_exp = (k > PRE) && (k < LAT);
      chk({tag, ".busy"}, W'(Busy), W'(k < LAT));
      chk({tag, ".done"}, W'(Done), W'(k == LAT));
      chk({tag, ".ffi"},  W'(Flipflop_Indicator), W'(ff_exp));
      chk({tag, ".sbt"},  SubByte_In_T, ff_exp ? t : '0);
      chk({tag, ".sbf"},  SubByte_In_F, ff_exp ? f : '0);
      if (k <= PRE + STG) chk({tag, ".mcs"}, W'(Multi_Cycle_State), (k > PRE) ? W'(k - PRE - 1) : '0);
      chk({tag, ".dot"},  Data_Out_T, cur_dout_t);
      chk({tag, ".dof"},  Data_Out_F, cur_dout_f);
      chk({tag, ".flt"},  W'(Fault), W'(exp_fault));
      if (do_inj && k == LAT - 1) inj = W'(1);
      if (hold) Start = 1'b1;
      else if (pulses && (k == 1 || k == 3)) begin
        Start = 1'b1;
        Data_In_T = {$urandom, $urandom, $urandom, $urandom};
        Data_In_F = ~Data_In_T;
      end else Start = 1'b0;
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".done"}, W'(Done), '0);
      chk({tag, ".busy"}, W'(Busy), '0);
      chk({tag, ".ffi"},  W'(Flipflop_Indicator), '0);
      chk({tag, ".sbt"},  SubByte_In_T, '0);
      chk({tag, ".dot"},  Data_Out_T, cur_dout_t);
      chk({tag, ".dof"},  Data_Out_F, cur_dout_f);
    end
  endtask

  initial begin
    logic [W-1:0] rt;
    logic [W-1:0] c63;
    logic [W-1:0] c9c;
    logic [W-1:0] c53;
    logic [W-1:0] ced;
    c63 = {16{8'h63}};
    c9c = {16{8'h9c}};
    c53 = {16{8'h53}};
    ced = {16{8'hed}};

    // Reset state
    #3;
    chk_all_zero("rst_async");
    tick(); tick();
    chk_all_zero("rst_held");
    Reset = 1'b1;
    idle_cycles("idle0", 2);

    // All bytes 0x00
    run_op("op00", '0, '1, c63, 1'b0, 1'b0, 1'b0);
    chk("op00.lit_t", Data_Out_T, c63);
    chk("op00.lit_f", Data_Out_F, c9c);
    idle_cycles("post00", 2);

    // 0x53 with Start held through Done, then a back-to-back random block
    run_op("op53", c53, ~c53, ced, 1'b1, 1'b0, 1'b0);
    chk("op53.lit_t", Data_Out_T, ced);
    chk("op53.lit_f", Data_Out_F, ~ced);
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("b2b", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b0);
    idle_cycles("postb2b", 1);

    // Start pulses while Busy are ignored: exactly one Done
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("ign", rt, ~rt, sbox_word(rt), 1'b0, 1'b1, 1'b0);
    idle_cycles("postign", 8);

    // Reset in the middle of an operation
    rt = {$urandom, $urandom, $urandom, $urandom};
    Data_In_T = rt;
    Data_In_F = ~rt;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    #2;
    Reset = 1'b0;
    #1;
    cur_dout_t = '0;
    cur_dout_f = '0;
    chk_all_zero("midrst");
    tick(); tick();
    chk_all_zero("midrst_held");
    Reset = 1'b1;
    idle_cycles("postrst", 6);

    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("fresh", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rt = {$urandom, $urandom, $urandom, $urandom};
      run_op("rnd", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b0);
      idle_cycles("rndgap", $urandom_range(0, 2));
    end

`ifdef DUAL_RAIL_CHECK_EN
    // Force a 11 pair on the S-box output during CAPT
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("inj", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b1);
    chk("inj.lit_t", Data_Out_T, '0);
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("sticky", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b0);
    chk("sticky.flt", W'(Fault), W'(1));
    #2;
    Reset = 1'b0;
    #1;
    exp_fault  = 1'b0;
    cur_dout_t = '0;
    cur_dout_f = '0;
    chk_all_zero("fltrst");
    tick();
    Reset = 1'b1;
    rt = {$urandom, $urandom, $urandom, $urandom};
    run_op("aftflt", rt, ~rt, sbox_word(rt), 1'b0, 1'b0, 1'b0);
`else
    chk("nochk.flt", W'(Fault), '0);
`endif

    idle_cycles("tail", 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
